frame_ram_arbiter: RTL and testbench
====================================

// Module: frame_ram_arbiter
// PURPOSE
//  Shares one single-port frame RAM (1-cycle read latency) among three requesters in the preprocessing
//  pipeline: 0 = camera writer, 1 = grayscale engine (read/write), 2 = filter reader.
//  Camera has fixed top priority; requesters 1/2 alternate round-robin.
//  Burst length is bounded so no requester starves.
//  Sits between the preprocessing sequencer's RAM enables and the physical frame RAM.
// PARAMETERS
//  ADDR_W     17  RAM address width
//  DATA_W     16  RAM data width
//  MAX_BURST  16  max consecutive beats per grant while another requester waits (>=1)
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          synchronous active-low reset
//  req        in   3          request per requester; held high for every beat wanted
//  we         in   3          1=write, 0=read, per requester, valid with req
//  addr       in   3*ADDR_W   per-requester address, slice i = [i*ADDR_W +: ADDR_W]
//  wdata      in   3*DATA_W   per-requester write data, slice i = [i*DATA_W +: DATA_W]
//  gnt        out  3          one-hot-or-zero grant (registered)
//  rvalid     out  3          one-cycle pulse: rdata holds read result for requester i
//  rdata      out  DATA_W     RAM read data (pass-through of ram_rdata)
//  ram_en     out  1          RAM access strobe
//  ram_we     out  1          RAM write enable
//  ram_addr   out  ADDR_W     RAM address
//  ram_wdata  out  DATA_W     RAM write data
//  ram_rdata  in   DATA_W     RAM read data, valid 1 cycle after read strobe
// BEHAVIOUR
//  Reset: gnt=0, rvalid=0, state=IDLE, beat_cnt=0, rr_ptr=1 (requester 1 wins the next tie).
//  FSM IDLE/OWN. IDLE: any req -> pick winner, gnt registered next cycle (req->gnt latency 1).
//  Pick: req[0] wins; else among req[1], req[2] the one at rr_ptr wins, else the other.
//  On grant to 1 or 2, rr_ptr toggles to the other.
//  OWN: beat = req[o] & gnt[o]; on beat drive ram_en=1, ram_we/addr/wdata from owner o's slices.
//  ram_* are combinational from gnt + owner's inputs; ram_en=0 when not granted.
//  beat_cnt increments per beat, clears on grant change.
//  Release when req[o]=0: re-arbitrate the same cycle among other reqs. Winner gets gnt next
//  cycle with no bubble; none pending -> IDLE, gnt=0.
//  Forced release: beat_cnt reaches MAX_BURST and any other req pending -> gnt[o] drops next
//  cycle and the winner is granted that cycle. No other pending -> keep grant, beat_cnt saturates.
//  The saturated grant is released as soon as another req appears (after the current beat).
//  Read beat in cycle t -> rvalid[o]=1 in t+1, using an owner register captured at t.
//  This holds even when gnt changed at t+1; writes never raise rvalid.
//  Owner drops req on its MAX_BURST-th beat: treated as plain release, no penalty.
//  MAX_BURST=1: ownership alternates every beat among waiting requesters.
//  Requester deasserts req while ungranted: no effect, no beat issued.
//  Reset mid-burst: gnt and rvalid clear at that edge; an in-flight read result is discarded.
// CONFIGURATION
//  CAM_PREEMPT_EN defined: req[0] rising while 1 or 2 owns -> owner's gnt drops next cycle,
//  camera granted that cycle, regardless of beat_cnt. The preempted requester re-arbitrates.
//  Undefined: camera waits for release or forced release (MAX_BURST) like any waiter.
// STRUCTURE
//  Shared package ram_arb_pkg: state encoding (IDLE, OWN), requester index constants
//  (REQ_CAM=0, REQ_GS=1, REQ_FLT=2), N_REQ=3.
//  Sub-module arb_pick: combinational priority + round-robin winner from req, rr_ptr, exclude mask.
//  Top holds FSM, beat counter, rr_ptr, rvalid pipeline and RAM mux.
// TESTING
//  1 req[1] alone, 4 reads addr 0..3 -> gnt[1] next cycle; ram_addr 0..3; rvalid[1] 4 pulses, each 1 cycle after its beat.
//  2 req[1], req[2] held, MAX_BURST=4 -> grants alternate 1,2,1 in 4-beat runs, no idle cycle between owners.
//  3 req[2] owning at beat 2, req[0] rises -> without CAM_PREEMPT_EN camera granted after beat 4 (MAX_BURST=4); with it, granted next cycle.
//  4 read beat on last cycle of requester 1 -> rvalid[1] (not rvalid[2]) asserted the following cycle.
//  5 rst_n=0 mid-burst with read in flight -> gnt=0, rvalid=0 next cycle; post-reset tie 1 vs 2 goes to 1.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared encodings for the frame RAM arbiter: FSM states, requester indices.
package ram_arb_pkg;
  localparam int N_REQ   = 3;
  localparam int REQ_CAM = 0;
  localparam int REQ_GS  = 1;
  localparam int REQ_FLT = 2;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

  function automatic logic [1:0] gnt2idx(input logic [N_REQ-1:0] g);
    gnt2idx = g[REQ_FLT] ? 2'(REQ_FLT) : (g[REQ_GS] ? 2'(REQ_GS) : 2'(REQ_CAM));
  endfunction
endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: camera first, then round-robin between
// grayscale and filter. Requesters in excl_i are not eligible.
module arb_pick
  import ram_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] excl_i,
  input  logic [1:0]       rr_ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             vld_o
);
  logic [N_REQ-1:0] cand;
  logic [1:0]       alt;

  assign cand  = req_i & ~excl_i;
  assign alt   = (rr_ptr_i == 2'(REQ_GS)) ? 2'(REQ_FLT) : 2'(REQ_GS);
  assign vld_o = |cand;

  always_comb begin
    gnt_o = '0;
    if (cand[REQ_CAM])       gnt_o[REQ_CAM]  = 1'b1;
    else if (cand[rr_ptr_i]) gnt_o[rr_ptr_i] = 1'b1;
    else if (cand[alt])      gnt_o[alt]      = 1'b1;
  end
endmodule

// File: rtl/frame_ram_arbiter.sv
// Three-way arbiter in front of a single-port frame RAM with bounded bursts.
// Define CAM_PREEMPT_EN to let the camera take the RAM from a current owner.
module frame_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
);
  localparam int              CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       own_idx;
  logic             beat, last_beat, others, preempt, do_arb;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_vld;

  arb_pick u_pick (
    .req_i   (req),
    .excl_i  (gnt_q),
    .rr_ptr_i(rr_q),
    .gnt_o   (pick_gnt),
    .vld_o   (pick_vld)
  );

  assign own_idx   = gnt2idx(gnt_q);
  assign beat      = |(req & gnt_q);
  assign last_beat = cnt_q >= (MAX_C - CNT_W'(1));
  assign others    = |(req & ~gnt_q);

`ifdef CAM_PREEMPT_EN
  assign preempt = req[REQ_CAM] & ~gnt_q[REQ_CAM];
`else
  assign preempt = 1'b0;
`endif

  assign ram_en    = beat;
  assign ram_we    = beat & we[own_idx];
  assign ram_addr  = addr[own_idx*ADDR_W +: ADDR_W];
  assign ram_wdata = wdata[own_idx*DATA_W +: DATA_W];
  assign rdata     = ram_rdata;
  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  // Read owner is captured at the beat, so rvalid follows the old owner across a handover.
  assign rvalid_d  = (beat & ~we[own_idx]) ? gnt_q : '0;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    do_arb  = 1'b0;
    case (state_q)
      IDLE: do_arb = |req;
      OWN: begin
        if (!beat) begin
          do_arb = 1'b1;
        end else begin
          if (cnt_q != MAX_C) cnt_d = cnt_q + CNT_W'(1);
          if ((last_beat && others) || preempt) do_arb = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_arb) begin
      gnt_d   = pick_gnt;
      state_d = pick_vld ? OWN : IDLE;
      cnt_d   = '0;
      if (pick_gnt[REQ_GS])       rr_d = 2'(REQ_FLT);
      else if (pick_gnt[REQ_FLT]) rr_d = 2'(REQ_GS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      cnt_q    <= '0;
      rr_q     <= 2'(REQ_GS);
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      rvalid_q <= rvalid_d;
    end
  end
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with MAX_BURST=4 and a 1-cycle RAM model.
module tb_frame_ram_arbiter;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    req = '0, we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [256];
  int            n_chk = 0, n_fail = 0;

  frame_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  task automatic do_reset;
    @(posedge clk); #1 rst_n = 1'b0; req = '0; we = '0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b exp 000", gnt); end
    n_chk++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid got %b exp 000", rvalid); end
    n_chk++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en got %b exp 0", ram_en); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_reads;
    do_reset();
    @(posedge clk); #1 req = 3'b010; we = '0; addr[AW +: AW] = '0;
    @(negedge clk);
    n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL s1_latency gnt got %b exp 000", gnt); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 addr[AW +: AW] = AW'(k);
      @(negedge clk);
      n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL s1_gnt k=%0d got %b exp 010", k, gnt); end
      n_chk++; if ({ram_en, ram_we} !== 2'b10) begin n_fail++; $display("FAIL s1_en_we k=%0d got %b exp 10", k, {ram_en, ram_we}); end
      n_chk++; if (ram_addr !== AW'(k)) begin n_fail++; $display("FAIL s1_addr got %0d exp %0d", ram_addr, k); end
      if (k > 0) begin
        n_chk++; if (rvalid !== 3'b010 || rdata !== DW'(16'hA000 + k - 1)) begin
          n_fail++; $display("FAIL s1_rd k=%0d got %b/%h exp 010/%h", k, rvalid, rdata, 16'hA000 + k - 1); end
      end
    end
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    n_chk++; if (rvalid !== 3'b010 || rdata !== 16'hA003) begin n_fail++; $display("FAIL s1_last_rd got %b/%h exp 010/a003", rvalid, rdata); end
    n_chk++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL s1_release_en got %b exp 0", ram_en); end
    @(posedge clk); @(negedge clk);
    n_chk++; if (gnt !== 3'b000 || rvalid !== 3'b000) begin n_fail++; $display("FAIL s1_idle got %b/%b exp 000/000", gnt, rvalid); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_g [12];
    exp_g = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100,
              3'b010, 3'b010, 3'b010, 3'b010};
    do_reset();
    @(posedge clk); #1 req = 3'b110; we = '0; addr[AW +: AW] = 17'h11; addr[2*AW +: AW] = 17'h22;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      n_chk++; if (gnt !== exp_g[k] || ram_en !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt k=%0d got %b/%b exp %b/1", k, gnt, ram_en, exp_g[k]); end
      n_chk++; if (ram_addr !== (exp_g[k][1] ? 17'h11 : 17'h22)) begin n_fail++; $display("FAIL b2b_addr k=%0d got %h", k, ram_addr); end
      if (k > 0) begin
        n_chk++; if (rvalid !== exp_g[k-1]) begin n_fail++; $display("FAIL b2b_rvalid k=%0d got %b exp %b", k, rvalid, exp_g[k-1]); end
      end
    end
    @(posedge clk); #1 req = '0;
    @(posedge clk);
  endtask

  task automatic test_camera;
    logic [2:0] exp_g [6];
`ifdef CAM_PREEMPT_EN
    exp_g = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_g = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001};
`endif
    do_reset();
    @(posedge clk); #1 req = 3'b100; we = 3'b001;
    addr[0 +: AW] = 17'h55; wdata[0 +: DW] = 16'hBEEF; addr[2*AW +: AW] = 17'h20;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1 if (k == 1) req = 3'b101;
      @(negedge clk);
      n_chk++; if (gnt !== exp_g[k]) begin n_fail++; $display("FAIL cam_gnt k=%0d got %b exp %b", k, gnt, exp_g[k]); end
      n_chk++; if (ram_we !== exp_g[k][0] || ram_addr !== (exp_g[k][0] ? 17'h55 : 17'h20)) begin
        n_fail++; $display("FAIL cam_bus k=%0d got we=%b addr=%h", k, ram_we, ram_addr); end
      if (exp_g[k][0]) begin
        n_chk++; if (ram_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL cam_wdata got %h exp beef", ram_wdata); end
      end
      if (k > 0) begin
        n_chk++; if (rvalid !== (exp_g[k-1][2] ? 3'b100 : 3'b000)) begin n_fail++; $display("FAIL cam_rvalid k=%0d got %b", k, rvalid); end
      end
    end
    @(posedge clk); #1 req = '0; we = '0;
    @(posedge clk);
  endtask

  task automatic test_saturate;
    do_reset();
    @(posedge clk); #1 req = 3'b010; we = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 if (k == 6) req = 3'b110;
      @(negedge clk);
      n_chk++; if (gnt !== (k < 7 ? 3'b010 : 3'b100)) begin n_fail++; $display("FAIL sat_gnt k=%0d got %b", k, gnt); end
    end
    @(posedge clk); #1 req = '0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    @(posedge clk); #1 req = 3'b010; we = '0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1 rst_n = 1'b0; req = 3'b110;
    @(negedge clk);
    n_chk++; if (ram_en !== 1'b1 || rvalid !== 3'b010) begin n_fail++; $display("FAIL rmb_pre got en=%b rv=%b exp 1/010", ram_en, rvalid); end
    @(posedge clk); @(negedge clk);
    n_chk++; if (gnt !== 3'b000 || rvalid !== 3'b000) begin n_fail++; $display("FAIL rmb_clear got %b/%b exp 000/000", gnt, rvalid); end
    #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rmb_tie got %b exp 010", gnt); end
    @(posedge clk); #1 req = '0;
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(16'hA000 + i);
    test_reset();
    test_single_reads();
    test_back_to_back();
    test_camera();
    test_saturate();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
